// File: rtl/rr_mux_arbiter.sv
// Two-requester round-robin arbiter driving a WIDTH-bit 2:1 packet mux toward one valid/ready sink.
// Optional beat-limit rotation is compiled in with `define RR_TIMEOUT_EN (limit = MAX_HOLD beats).
module rr_mux_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic [WIDTH-1:0] a,
    input  logic             last_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] b,
    input  logic             last_b,
    input  logic             z_ready,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] z,
    output logic             z_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("rr_mux_arbiter: MAX_HOLD must be >= 1");
    end

    state_t state_q, state_d;
    logic   sel_q, sel_d;
    logic   prio_q, prio_d;

    logic granted, owner_b;
    logic req_x, last_x, req_o;
    logic xfer, timeout, release_g;

    // Requester-relative view of the current owner ("x") and the other side.
    assign granted   = (state_q != IDLE);
    assign owner_b   = (state_q == GNT_B);
    assign req_x     = owner_b ? req_b  : req_a;
    assign last_x    = owner_b ? last_b : last_a;
    assign req_o     = owner_b ? req_a  : req_b;
    assign xfer      = granted & req_x & z_ready;
    assign release_g = granted & ((xfer & (last_x | timeout)) | (~req_x & z_ready));

`ifdef RR_TIMEOUT_EN
    localparam int            CW       = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_HOLD);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Rotation fires on the beat that brings the count to MAX_HOLD, only if the other side waits.
    assign timeout = xfer & req_o & (cnt_q >= CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (release_g) begin
            cnt_d = '0;
        end else if (xfer && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (req_a && (!req_b || !prio_q)) begin
                    state_d = GNT_A;
                    sel_d   = 1'b0;
                end else if (req_b) begin
                    state_d = GNT_B;
                    sel_d   = 1'b1;
                end
            end
            GNT_A, GNT_B: begin
                if (release_g) begin
                    // The side just released loses priority; a waiting peer takes over with no bubble.
                    prio_d = ~owner_b;
                    if (req_o) begin
                        state_d = owner_b ? GNT_A : GNT_B;
                        sel_d   = ~owner_b;
                    end else if (!req_x) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            prio_q  <= prio_d;
        end
    end

    assign gnt_a   = (state_q == GNT_A);
    assign gnt_b   = (state_q == GNT_B);
    assign sel     = sel_q;
    assign z       = sel_q ? b : a;
    assign z_valid = (gnt_a & req_a) | (gnt_b & req_b);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Testbench for rr_mux_arbiter: directed scenarios plus a randomized phase against a behavioural model.
module tb_rr_mux_arbiter;

    localparam int W  = 8;
    localparam int MH = 4;
`ifdef RR_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req_a = 1'b0, req_b = 1'b0, last_a = 1'b0, last_b = 1'b0, z_ready = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         gnt_a, gnt_b, sel, z_valid;
    logic [W-1:0] z;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .a(a), .last_a(last_a),
        .req_b(req_b), .b(b), .last_b(last_b),
        .z_ready(z_ready),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .z(z), .z_valid(z_valid)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester-side stimulus state (index 0 = a, 1 = b)
    bit           act[2];
    bit           pause[2];
    int           rem[2];
    logic [W-1:0] seq[2];
    logic [W-1:0] eseq[2];
    logic [W-1:0] inc = 8'd1;
    bit           rnd = 1'b0;
    int           auto_len = 0;
    int           log_q[$];

    // Reference model: owner 0 = none, 1 = a, 2 = b; prio 0 prefers a
    int m_own = 0, m_prio = 0, m_sel = 0, m_cnt = 0;

    task automatic drive();
        req_a  = act[0] && !pause[0];
        a      = seq[0];
        last_a = (rem[0] == 1);
        req_b  = act[1] && !pause[1];
        b      = seq[1];
        last_b = (rem[1] == 1);
    endtask

    task automatic start_pkt(input int i, input int len, input logic [W-1:0] first);
        act[i]   = 1'b1;
        pause[i] = 1'b0;
        rem[i]   = len;
        seq[i]   = first;
        eseq[i]  = first;
        drive();
    endtask

    task automatic model_reset();
        m_own = 0; m_prio = 0; m_sel = 0; m_cnt = 0;
    endtask

    task automatic cycle();
        bit ra, rb, rx, ro, lx, xf, tout, rel;
        bit cons[2];
        int x, n_own, n_prio, n_sel, n_cnt;
        @(negedge clk);
        ra = req_a;
        rb = req_b;
        check("gnt_a", gnt_a, m_own == 1);
        check("gnt_b", gnt_b, m_own == 2);
        check("sel", sel, m_sel);
        check("z_valid", z_valid, (m_own == 1 && ra) || (m_own == 2 && rb));
        check("z_mux", z, (m_sel != 0) ? b : a);
        if (m_own != 0 && ((m_own == 1) ? ra : rb))
            check("z_data", z, eseq[m_own-1]);
        cons[0] = gnt_a & req_a & z_ready;
        cons[1] = gnt_b & req_b & z_ready;
        if (cons[0]) log_q.push_back(256 + int'(a));
        if (cons[1]) log_q.push_back(512 + int'(b));

        n_own = m_own; n_prio = m_prio; n_sel = m_sel; n_cnt = m_cnt;
        if (m_own == 0) begin
            if (ra && (!rb || m_prio == 0)) n_own = 1;
            else if (rb)                   n_own = 2;
        end else begin
            x    = m_own - 1;
            rx   = (x == 1) ? rb : ra;
            ro   = (x == 1) ? ra : rb;
            lx   = (x == 1) ? last_b : last_a;
            xf   = rx && z_ready;
            tout = TO && xf && ro && (m_cnt + 1 >= MH);
            rel  = (xf && (lx || tout)) || (!rx && z_ready);
            if (xf) begin
                eseq[x] = eseq[x] + inc;
                if (m_cnt < MH) n_cnt = m_cnt + 1;
            end
            if (rel) begin
                n_prio = (x == 0) ? 1 : 0;
                n_cnt  = 0;
                n_own  = ro ? (2 - x) : (rx ? m_own : 0);
            end
        end
        if (n_own != 0) n_sel = (n_own == 2) ? 1 : 0;

        @(posedge clk);
        #1;
        m_own = n_own; m_prio = n_prio; m_sel = n_sel; m_cnt = n_cnt;
        for (int i = 0; i < 2; i++) begin
            if (cons[i]) begin
                seq[i] = seq[i] + inc;
                rem[i]--;
                if (rem[i] == 0) begin
                    if (auto_len > 0) rem[i] = auto_len;
                    else              act[i] = 1'b0;
                end
            end
            if (rnd) begin
                if (!act[i] && ($urandom % 3 == 0)) begin
                    act[i] = 1'b1;
                    rem[i] = $urandom_range(1, 5);
                end
                pause[i] = act[i] && ($urandom % 12 == 0);
            end
        end
        if (rnd) z_ready = ($urandom % 4 != 0);
        drive();
    endtask

    task automatic drain();
        auto_len = 0;
        z_ready  = 1'b1;
        pause[0] = 1'b0;
        pause[1] = 1'b0;
        drive();
        for (int k = 0; k < 60 && (act[0] || act[1] || m_own != 0); k++) cycle();
        check("drain_idle", {act[0], act[1], m_own != 0}, 3'b000);
    endtask

    task automatic async_reset_pulse();
        #1 rst_n = 1'b0;
        #1;
        check("arst_gnt_a", gnt_a, 1'b0);
        check("arst_gnt_b", gnt_b, 1'b0);
        check("arst_sel", sel, 1'b0);
        check("arst_z_valid", z_valid, 1'b0);
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_q[$];
        int o0;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; pause[i] = 1'b0; rem[i] = 0; seq[i] = '0; eseq[i] = '0;
        end
        model_reset();

        // Reset held with both requesting
        #1 rst_n = 1'b0;
        z_ready = 1'b1;
        start_pkt(0, 2, 8'h01);
        start_pkt(1, 2, 8'h81);
        #2;
        check("rst_gnt_a", gnt_a, 1'b0);
        check("rst_gnt_b", gnt_b, 1'b0);
        check("rst_sel", sel, 1'b0);
        check("rst_z_valid", z_valid, 1'b0);
        check("rst_z", z, a);
        @(posedge clk);
        #2;
        check("rst_hold_gnt", {gnt_a, gnt_b}, 2'b00);
        rst_n = 1'b1;
        cycle();
        check("rst_first_gnt_a", gnt_a, 1'b1);
        drain();

        // Single 3-beat stream on a
        inc = 8'h11;
        log_q.delete();
        start_pkt(0, 3, 8'h11);
        for (int k = 0; k < 6; k++) cycle();
        exp_q = '{256 + 'h11, 256 + 'h22, 256 + 'h33};
        check("single_len", log_q.size(), 3);
        for (int k = 0; k < 3 && k < log_q.size(); k++) check("single_beat", log_q[k], exp_q[k]);
        check("single_idle_zv", z_valid, 1'b0);
        drain();

        // Fairness with back-to-back 2-beat packets
        inc = 8'd1;
        auto_len = 2;
        start_pkt(0, 2, 8'h20);
        start_pkt(1, 2, 8'h40);
        cycle();
        log_q.delete();
        for (int k = 0; k < 8; k++) cycle();
        check("fair_len", log_q.size(), 8);
        o0 = (log_q.size() > 0) ? (log_q[0] >> 8) : 0;
        for (int k = 0; k < log_q.size(); k++)
            check("fair_owner", log_q[k] >> 8, (((k / 2) % 2) == 0) ? o0 : 3 - o0);
        drain();

        // Backpressure mid-packet on b
        log_q.delete();
        start_pkt(1, 4, 8'h60);
        for (int k = 0; k < 12; k++) begin
            z_ready = !(k >= 3 && k <= 6);
            cycle();
        end
        exp_q = '{512 + 'h60, 512 + 'h61, 512 + 'h62, 512 + 'h63};
        check("bp_len", log_q.size(), 4);
        for (int k = 0; k < 4 && k < log_q.size(); k++) check("bp_beat", log_q[k], exp_q[k]);
        drain();

        // Abort on a hands the grant to b at the next edge
        log_q.delete();
        start_pkt(0, 4, 8'h70);
        cycle();
        start_pkt(1, 1, 8'h90);
        cycle();
        pause[0] = 1'b1;
        drive();
        cycle();
        check("abort_gnt_b", gnt_b, 1'b1);
        check("abort_sel", sel, 1'b1);
        pause[0] = 1'b0;
        drive();
        for (int k = 0; k < 2; k++) cycle();
        check("abort_first", (log_q.size() > 0) ? log_q[0] : -1, 256 + 'h70);
        check("abort_second", (log_q.size() > 1) ? log_q[1] : -1, 512 + 'h90);
        drain();

        // Long packet on a while b waits
        log_q.delete();
        start_pkt(0, 10, 8'h00);
        cycle();
        start_pkt(1, 1, 8'hB0);
        for (int k = 0; k < 16; k++) cycle();
        exp_q.delete();
        if (TO) begin
            for (int k = 0; k < 4; k++) exp_q.push_back(256 + k);
            exp_q.push_back(512 + 'hB0);
            for (int k = 4; k < 10; k++) exp_q.push_back(256 + k);
        end else begin
            for (int k = 0; k < 10; k++) exp_q.push_back(256 + k);
            exp_q.push_back(512 + 'hB0);
        end
        check("hold_len", log_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) check("hold_beat", log_q[k], exp_q[k]);
        drain();

        // Randomized traffic with occasional asynchronous reset pulses
        rnd = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            cycle();
            if (k % 700 == 350) async_reset_pulse();
        end
        rnd = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
